// File: rtl/de0_nano_sw_debounce.sv
// Switch debouncer for the DE0-Nano slide switches.
// Each channel passes through a 2-FF synchronizer. A new level is accepted
// only after it has held for STABLE_TICKS ticks of a shared, free-running
// prescaler. sw_clean feeds the switch PIO in_port. sw_changed pulses for
// one cycle on every accepted change.
module de0_nano_sw_debounce #(
  parameter int WIDTH        = 4,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_changed
);

  // Prescaler width. It is kept at least 1 bit so that TICK_DIV=1 still elaborates.
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Stability counter width. It is kept at least 1 bit so that STABLE_TICKS=1 still elaborates.
  localparam int CW = ($clog2(STABLE_TICKS + 1) > 1) ? $clog2(STABLE_TICKS + 1) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [CW-1:0]    cnt [WIDTH];

  // Two-stage synchronizer for the asynchronous switch pins. Only s2 is used downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  // Free-running prescaler shared by every channel. It wraps after TICK_DIV cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  // The tick is high in the last cycle of each prescaler period.
  // With TICK_DIV=1 the count never leaves 0, so the tick is high every cycle.
  assign tick = (tick_cnt == TICK_LAST);

  // Per-channel stability counters.
  // Any cycle in which s2 agrees with the clean level discards the progress
  // made so far, so a glitch shorter than the window never gets through.
  // A new level is accepted on the tick that completes the window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_clean   <= '0;
      sw_changed <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sw_changed <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == sw_clean[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          if (cnt[i] == CNT_LAST) begin
            sw_clean[i]   <= s2[i];
            sw_changed[i] <= 1'b1;
            cnt[i]        <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_de0_nano_sw_debounce.sv
// Self-checking bench for de0_nano_sw_debounce.
// dut1 uses TICK_DIV=4 and STABLE_TICKS=3. dut2 uses TICK_DIV=1 and STABLE_TICKS=1.
// Each stimulus step that should lead to an update pushes the expected clean
// value, the expected pulse mask and the allowed edge window into a queue.
// The monitors pop one entry per observed update.
module tb_de0_nano_sw_debounce;

  localparam int D1 = 4;
  localparam int S1 = 3;
  localparam int D2 = 1;
  localparam int S2 = 1;

  typedef struct {
    string      tag;
    logic [3:0] clean;
    logic [3:0] changed;
    int         lo;
    int         hi;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic [3:0] sw_raw1, sw_clean1, sw_changed1;
  logic [3:0] sw_raw2, sw_clean2, sw_changed2;

  exp_t q1[$];
  exp_t q2[$];
  int   edge_n  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [3:0] prev_clean1 = '0;
  logic [3:0] prev_clean2 = '0;

  de0_nano_sw_debounce #(.WIDTH(4), .TICK_DIV(D1), .STABLE_TICKS(S1)) dut1 (
    .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw1),
    .sw_clean(sw_clean1), .sw_changed(sw_changed1)
  );

  de0_nano_sw_debounce #(.WIDTH(4), .TICK_DIV(D2), .STABLE_TICKS(S2)) dut2 (
    .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw2),
    .sw_clean(sw_clean2), .sw_changed(sw_changed2)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count active edges. Stimulus and monitors read the count on the falling edge.
  always @(posedge clk) edge_n <= edge_n + 1;

  // Comparison with failure counting.
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks that an observed update landed inside its allowed edge window.
  task automatic checkWindow(input string tag, input int at, input int lo, input int hi);
    n_checks++;
    assert (at >= lo && at <= hi) else begin
      n_fail++;
      $error("[TB] FAIL %s_window: observed edge %0d expected %0d..%0d", tag, at, lo, hi);
    end
  endtask

  // Drives new raw switches on a falling edge.
  // The next rising edge is the sampling edge k. When an update is expected,
  // the entry pushed to the queue allows the update edge to fall in
  // k+1+(S-1)*D+1 .. k+1+S*D.
  task automatic applyStimulus(input int which, input logic [3:0] raw, input bit push,
                               input string tag, input logic [3:0] exp_clean,
                               input logic [3:0] exp_changed);
    int k;
    @(negedge clk);
    k = edge_n + 1;
    if (which == 1) begin
      sw_raw1 = raw;
      if (push) q1.push_back('{tag, exp_clean, exp_changed, k + 2 + (S1 - 1) * D1, k + 1 + S1 * D1});
    end else begin
      sw_raw2 = raw;
      if (push) q2.push_back('{tag, exp_clean, exp_changed, k + 2 + (S2 - 1) * D2, k + 1 + S2 * D2});
    end
  endtask

  // Waits a bounded number of cycles for a queue to empty.
  // A few extra cycles are then allowed so that a stretched pulse is caught.
  task automatic drain(input int which, input string tag);
    int waited = 0;
    while (((which == 1) ? q1.size() : q2.size()) != 0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_drained"}, 8'((which == 1) ? q1.size() : q2.size()), 8'd0);
    repeat (3) @(negedge clk);
  endtask

  // dut1 monitor. Every change of sw_clean or nonzero sw_changed must match
  // the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_clean1 = '0;
    end else if (sw_changed1 != 4'h0 || sw_clean1 != prev_clean1) begin
      if (q1.size() == 0) begin
        checkOutput("dut1_unexpected_update", {sw_clean1, sw_changed1}, {prev_clean1, 4'h0});
      end else begin
        e = q1.pop_front();
        checkOutput({e.tag, "_clean"}, {4'h0, sw_clean1}, {4'h0, e.clean});
        checkOutput({e.tag, "_changed"}, {4'h0, sw_changed1}, {4'h0, e.changed});
        checkWindow(e.tag, edge_n, e.lo, e.hi);
      end
      prev_clean1 = sw_clean1;
    end
  end

  // dut2 monitor. It follows the same rules as the dut1 monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_clean2 = '0;
    end else if (sw_changed2 != 4'h0 || sw_clean2 != prev_clean2) begin
      if (q2.size() == 0) begin
        checkOutput("dut2_unexpected_update", {sw_clean2, sw_changed2}, {prev_clean2, 4'h0});
      end else begin
        e = q2.pop_front();
        checkOutput({e.tag, "_clean"}, {4'h0, sw_clean2}, {4'h0, e.clean});
        checkOutput({e.tag, "_changed"}, {4'h0, sw_changed2}, {4'h0, e.changed});
        checkWindow(e.tag, edge_n, e.lo, e.hi);
      end
      prev_clean2 = sw_clean2;
    end
  end

  // Directed sequence.
  initial begin
    logic [3:0] r;
    int k;
    reset_n = 1'b0;
    sw_raw1 = 4'hF;
    sw_raw2 = 4'h0;

    // Raw switches held high through reset. Outputs stay cleared while reset is low.
    repeat (4) @(negedge clk);
    checkOutput("t1_reset_clean", {4'h0, sw_clean1}, 8'h00);
    checkOutput("t1_reset_changed", {4'h0, sw_changed1}, 8'h00);
    checkOutput("t1_reset_clean_dut2", {4'h0, sw_clean2}, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    k = edge_n + 1;
    q1.push_back('{"t1", 4'hF, 4'hF, k + 2 + (S1 - 1) * D1, k + 1 + S1 * D1});
    drain(1, "t1");

    // Return to clean 0, then apply a 6-cycle pulse on bit 0 that must be rejected.
    applyStimulus(1, 4'h0, 1'b1, "t2_pre", 4'h0, 4'hF);
    drain(1, "t2_pre");
    applyStimulus(1, 4'h1, 1'b0, "", 4'h0, 4'h0);
    repeat (5) @(negedge clk);
    applyStimulus(1, 4'h0, 1'b0, "", 4'h0, 4'h0);
    repeat (20) @(negedge clk);
    checkOutput("t2_clean", {4'h0, sw_clean1}, 8'h00);

    // Bounce bit 1 every 3 cycles, 10 toggles, then settle high.
    for (int i = 0; i < 10; i++) begin
      r = sw_raw1;
      r[1] = ~r[1];
      applyStimulus(1, r, 1'b0, "", 4'h0, 4'h0);
      repeat (2) @(negedge clk);
    end
    applyStimulus(1, 4'b0010, 1'b1, "t3", 4'b0010, 4'b0010);
    drain(1, "t3");

    // Simultaneous changes on two bits must land on one edge with a shared pulse.
    applyStimulus(1, 4'b1000, 1'b1, "t4_pre", 4'b1000, 4'b1010);
    drain(1, "t4_pre");
    applyStimulus(1, 4'b0100, 1'b1, "t4", 4'b0100, 4'b1100);
    drain(1, "t4");

    // Reset while bit 0 is two ticks into its window.
    // Ten falling edges after the stimulus, two ticks have surely passed and the third has not.
    applyStimulus(1, 4'b0101, 1'b0, "", 4'h0, 4'h0);
    repeat (10) @(negedge clk);
    checkOutput("t5_pre_clean", {4'h0, sw_clean1}, 8'h04);
    reset_n = 1'b0;
    #1;
    checkOutput("t5_async_clean", {4'h0, sw_clean1}, 8'h00);
    checkOutput("t5_async_changed", {4'h0, sw_changed1}, 8'h00);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    k = edge_n + 1;
    q1.push_back('{"t5", 4'b0101, 4'b0101, k + 2 + (S1 - 1) * D1, k + 1 + S1 * D1});
    drain(1, "t5");

    // Minimal configuration: the update follows the sampling edge by exactly 2 edges.
    applyStimulus(2, 4'b1000, 1'b1, "t6", 4'b1000, 4'b1000);
    drain(2, "t6");
    checkOutput("t6_clean_hold", {4'h0, sw_clean2}, 8'h08);

    checkOutput("final_q1_empty", 8'(q1.size()), 8'd0);
    checkOutput("final_q2_empty", 8'(q2.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
